// File: rtl/fb_write_arbiter.sv
// Framebuffer port-A write arbiter: full-screen clear engine with priority over raster pixel writes.
// Define FB_BOUNDS_CHECK_EN to drop and count out-of-range raster pixels instead of writing them wrapped.
module fb_write_arbiter #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        clear_start,
  input  logic [7:0]  clear_color,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [8:0]  px_x,
  input  logic [7:0]  px_y,
  input  logic [7:0]  px_color,
  output logic        fb_wea,
  output logic [16:0] fb_addra,
  output logic [7:0]  fb_dina,
  output logic [15:0] px_drop_cnt
);

  localparam int unsigned PIXELS    = WIDTH * HEIGHT;
  localparam logic [16:0] LAST_ADDR = 17'(PIXELS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [16:0] r_clr_cnt;
  logic [16:0] w_clr_cnt_nxt;
  logic [7:0]  r_clr_color;
  logic [7:0]  w_clr_color_nxt;
  logic        r_fb_wea;
  logic        w_fb_wea_nxt;
  logic [16:0] r_fb_addra;
  logic [16:0] w_fb_addra_nxt;
  logic [7:0]  r_fb_dina;
  logic [7:0]  w_fb_dina_nxt;
  logic        r_clear_busy;
  logic        w_clear_busy_nxt;
  logic        r_clear_done;
  logic        w_clear_done_nxt;

  logic        w_px_accept;
  logic        w_px_oob;
  logic [16:0] w_px_addr;

  // A pending clear request blocks the raster handshake in the same cycle.
  assign px_ready    = (r_state == IDLE) && !clear_start;
  assign w_px_accept = px_valid && px_ready;
  assign w_px_addr   = 17'(32'(px_y) * WIDTH + 32'(px_x));

`ifdef FB_BOUNDS_CHECK_EN
  logic [15:0] r_drop_cnt;

  assign w_px_oob = (32'(px_x) >= WIDTH) || (32'(px_y) >= HEIGHT);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_drop_cnt <= 16'd0;
    end else if (w_px_accept && w_px_oob && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign px_drop_cnt = r_drop_cnt;
`else
  assign w_px_oob    = 1'b0;
  assign px_drop_cnt = 16'd0;
`endif

  // The counter always equals the address currently presented during a clear.
  always_comb begin
    w_state_nxt      = r_state;
    w_clr_cnt_nxt    = r_clr_cnt;
    w_clr_color_nxt  = r_clr_color;
    w_fb_wea_nxt     = 1'b0;
    w_fb_addra_nxt   = r_fb_addra;
    w_fb_dina_nxt    = r_fb_dina;
    w_clear_busy_nxt = 1'b0;
    w_clear_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_start) begin
          w_state_nxt      = CLEAR;
          w_clr_cnt_nxt    = 17'd0;
          w_clr_color_nxt  = clear_color;
          w_fb_wea_nxt     = 1'b1;
          w_fb_addra_nxt   = 17'd0;
          w_fb_dina_nxt    = clear_color;
          w_clear_busy_nxt = 1'b1;
          w_clear_done_nxt = (LAST_ADDR == 17'd0);
        end else if (w_px_accept && !w_px_oob) begin
          w_fb_wea_nxt   = 1'b1;
          w_fb_addra_nxt = w_px_addr;
          w_fb_dina_nxt  = px_color;
        end
      end
      CLEAR: begin
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
        end else begin
          w_clr_cnt_nxt    = r_clr_cnt + 17'd1;
          w_fb_wea_nxt     = 1'b1;
          w_fb_addra_nxt   = r_clr_cnt + 17'd1;
          w_fb_dina_nxt    = r_clr_color;
          w_clear_busy_nxt = 1'b1;
          w_clear_done_nxt = ((r_clr_cnt + 17'd1) == LAST_ADDR);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_clr_cnt    <= 17'd0;
      r_clr_color  <= 8'd0;
      r_fb_wea     <= 1'b0;
      r_fb_addra   <= 17'd0;
      r_fb_dina    <= 8'd0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_clr_color  <= w_clr_color_nxt;
      r_fb_wea     <= w_fb_wea_nxt;
      r_fb_addra   <= w_fb_addra_nxt;
      r_fb_dina    <= w_fb_dina_nxt;
      r_clear_busy <= w_clear_busy_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  assign fb_wea     = r_fb_wea;
  assign fb_addra   = r_fb_addra;
  assign fb_dina    = r_fb_dina;
  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;

endmodule
